// File: rtl/svi_chan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : svi_chan_pkg
// Description : Shared defaults and helpers for the channel FIFO bank.
//               Holds the default channel count, data width and depth, and
//               the occupancy-counter width function.
// Revision    : 1.0  initial release
// ============================================================================
package svi_chan_pkg;

    localparam int C_NCH_DEFAULT   = 8;
    localparam int C_W_DEFAULT     = 1;
    localparam int C_DEPTH_DEFAULT = 2;

    // Occupancy must be able to represent both 0 and DEPTH, hence one more
    // bit than the pointer width.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/svi_chan_if.sv
`default_nettype none
// ============================================================================
// Module      : I_chan
// Description : Valid/ready streaming channel.
//               SRC drives data and valid and receives ready.
//               SNK drives ready and receives data and valid.
// Revision    : 1.0  initial release
// ============================================================================
interface I_chan #(
    parameter int W = svi_chan_pkg::C_W_DEFAULT
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport SRC (output data, output valid, input ready);
    modport SNK (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/svi_chan_fifo.sv
`default_nettype none
// ============================================================================
// Module      : svi_chan_fifo
// Description : Single-channel first-word-fall-through FIFO.
//   clk, rst           : clock, asynchronous active-high reset (pre-synchronised
//                        deassertion)
//   en                 : enable; low holds all state
//   flush              : synchronous clear of pointers, occupancy and ovf
//   wr_valid/data/ready: write side handshake
//   rd_valid/data/ready: read side handshake, data shows the oldest entry
//   full, empty, ovf   : status; ovf is sticky until flush or reset
// Revision    : 1.0  initial release
// ============================================================================
module svi_chan_fifo
    import svi_chan_pkg::*;
#(
    parameter int W     = C_W_DEFAULT,
    parameter int DEPTH = C_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic         wr_valid,
    input  logic [W-1:0] wr_data,
    output logic         wr_ready,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    input  logic         rd_ready,
    output logic         full,
    output logic         empty,
    output logic         ovf
);

    localparam int                 c_ADDR_W   = $clog2(DEPTH);
    localparam int                 c_OCC_W    = occ_width(DEPTH);
    localparam logic [c_OCC_W-1:0] c_OCC_FULL = c_OCC_W'(DEPTH);

    logic [W-1:0]        r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_OCC_W-1:0]  r_occ;
    logic                r_ovf;
    logic                w_push;
    logic                w_pop;

    assign full     = (r_occ == c_OCC_FULL);
    assign empty    = (r_occ == '0);
    // Ready is also masked by reset so nothing is accepted while the
    // synchronised reset is still asserted.
    assign wr_ready = en & ~full & ~rst;
    assign rd_valid = en & ~empty;
    assign rd_data  = r_mem[r_rd_ptr];
    assign ovf      = r_ovf;

    // Flush wins over any handshake in the same cycle.
    assign w_push   = wr_valid & wr_ready & ~flush;
    assign w_pop    = rd_valid & rd_ready & ~flush;

    // Storage is deliberately left unreset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_ovf    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the natural pointer wrap is exact.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + c_OCC_W'(1);
                2'b01:   r_occ <= r_occ - c_OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
            if (en && wr_valid && full) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/svi_chan_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module      : svi_chan_fifo_bank
// Description : Bank of NCH independent FWFT FIFOs on valid/ready channels.
//   i_clk    : clock
//   i_arst   : asynchronous active-high reset, deassertion synchronised here
//   en       : global enable; low stalls every channel
//   i_flush  : synchronous flush of every channel (independent of en)
//   p_in     : NCH input channels (this block is the sink)
//   p_out    : NCH output channels (this block is the source)
//   o_full   : per-channel full flag
//   o_empty  : per-channel empty flag
//   o_ovf    : per-channel sticky overflow (valid offered while full)
// Revision    : 1.0  initial release
// ============================================================================
module svi_chan_fifo_bank
    import svi_chan_pkg::*;
#(
    parameter int NCH   = C_NCH_DEFAULT,
    parameter int W     = C_W_DEFAULT,
    parameter int DEPTH = C_DEPTH_DEFAULT
) (
    input  logic           i_clk,
    input  logic           i_arst,
    input  logic           en,
    input  logic           i_flush,
    I_chan.SNK             p_in  [NCH-1:0],
    I_chan.SRC             p_out [NCH-1:0],
    output logic [NCH-1:0] o_full,
    output logic [NCH-1:0] o_empty,
    output logic [NCH-1:0] o_ovf
);

    // Reset asserts immediately through the async set, and releases only
    // after two clean clock edges so the channel logic never sees a
    // metastable deassertion.
    logic [1:0] r_rst_sync;
    logic       w_rst;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst = r_rst_sync[1];

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        logic         w_wr_valid;
        logic [W-1:0] w_wr_data;
        logic         w_wr_ready;
        logic         w_rd_valid;
        logic [W-1:0] w_rd_data;
        logic         w_rd_ready;

        assign w_wr_valid     = p_in[g].valid;
        assign w_wr_data      = p_in[g].data;
        assign p_in[g].ready  = w_wr_ready;
        assign p_out[g].valid = w_rd_valid;
        assign p_out[g].data  = w_rd_data;
        assign w_rd_ready     = p_out[g].ready;

        svi_chan_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (i_clk),
            .rst      (w_rst),
            .en       (en),
            .flush    (i_flush),
            .wr_valid (w_wr_valid),
            .wr_data  (w_wr_data),
            .wr_ready (w_wr_ready),
            .rd_valid (w_rd_valid),
            .rd_data  (w_rd_data),
            .rd_ready (w_rd_ready),
            .full     (o_full[g]),
            .empty    (o_empty[g]),
            .ovf      (o_ovf[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_svi_chan_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_svi_chan_fifo_bank
// Description : Self-checking bench for svi_chan_fifo_bank. A queue-per-
//               channel reference model tracks accepted data; every falling
//               edge the monitor compares the DUT outputs against it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_svi_chan_fifo_bank;

    localparam int NCH   = 8;
    localparam int W     = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           arst;
    logic           en;
    logic           flush;
    logic [NCH-1:0] in_valid;
    logic [NCH-1:0] in_ready;
    logic [NCH-1:0] out_valid;
    logic [NCH-1:0] out_ready;
    logic [NCH-1:0] full;
    logic [NCH-1:0] empty;
    logic [NCH-1:0] ovf;
    logic [W-1:0]   in_data  [NCH];
    logic [W-1:0]   out_data [NCH];

    I_chan #(.W(W)) p_in  [NCH-1:0] ();
    I_chan #(.W(W)) p_out [NCH-1:0] ();

    for (genvar g = 0; g < NCH; g++) begin : g_tb_chan
        assign p_in[g].valid  = in_valid[g];
        assign p_in[g].data   = in_data[g];
        assign in_ready[g]    = p_in[g].ready;
        assign out_valid[g]   = p_out[g].valid;
        assign out_data[g]    = p_out[g].data;
        assign p_out[g].ready = out_ready[g];
    end

    svi_chan_fifo_bank #(
        .NCH   (NCH),
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_arst  (arst),
        .en      (en),
        .i_flush (flush),
        .p_in    (p_in),
        .p_out   (p_out),
        .o_full  (full),
        .o_empty (empty),
        .o_ovf   (ovf)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input int ch,
                         input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s ch%0d at %0t: got %0h expected %0h",
                     name, ch, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model + monitor
    // ------------------------------------------------------------------
    logic [W-1:0] mq  [NCH][$];
    bit           mov [NCH];
    int           quiet    = 0;
    int           rst_gen  = 0;
    int           rst_seen = 0;

    always @(negedge clk) begin
        if (arst || (rst_gen != rst_seen)) begin
            rst_seen = rst_gen;
            quiet    = 3;
            for (int i = 0; i < NCH; i++) begin
                mq[i].delete();
                mov[i] = 1'b0;
            end
            check("rst_empty", -1, 64'(empty),     64'({NCH{1'b1}}));
            check("rst_full",  -1, 64'(full),      64'(0));
            check("rst_ovf",   -1, 64'(ovf),       64'(0));
            check("rst_ready", -1, 64'(in_ready),  64'(0));
            check("rst_valid", -1, 64'(out_valid), 64'(0));
        end else begin
            for (int i = 0; i < NCH; i++) begin
                int n;
                bit ev;
                bit er;
                n  = mq[i].size();
                ev = en && (n > 0);
                er = en && (n < DEPTH);
                check("empty", i, 64'(empty[i]),     64'(n == 0));
                check("full",  i, 64'(full[i]),      64'(n == DEPTH));
                check("ovf",   i, 64'(ovf[i]),       64'(mov[i]));
                check("valid", i, 64'(out_valid[i]), 64'(ev));
                if (quiet == 0) begin
                    check("ready", i, 64'(in_ready[i]), 64'(er));
                end
                if (ev) begin
                    check("data", i, 64'(out_data[i]), 64'(mq[i][0]));
                end
                if (flush) begin
                    mq[i].delete();
                    mov[i] = 1'b0;
                end else if (en && quiet == 0) begin
                    if (in_valid[i] && n == DEPTH) begin
                        mov[i] = 1'b1;
                    end
                    if (ev && out_ready[i]) begin
                        void'(mq[i].pop_front());
                    end
                    if (er && in_valid[i]) begin
                        mq[i].push_back(in_data[i]);
                    end
                end
            end
            if (quiet > 0) begin
                quiet--;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid  = '0;
        out_ready = '0;
        flush     = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            in_data[i] = '0;
        end
    endtask

    // Reset pulse placed strictly between two rising edges; outputs must
    // already show reset values before the next edge.
    task automatic pulse_reset();
        #1;
        arst = 1'b1;
        rst_gen++;
        #1;
        check("arst_empty", -1, 64'(empty),     64'({NCH{1'b1}}));
        check("arst_full",  -1, 64'(full),      64'(0));
        check("arst_ovf",   -1, 64'(ovf),       64'(0));
        check("arst_ready", -1, 64'(in_ready),  64'(0));
        check("arst_valid", -1, 64'(out_valid), 64'(0));
        #1;
        arst = 1'b0;
    endtask

    initial begin
        arst = 1'b1;
        en   = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #2 arst = 1'b0;
        repeat (4) step();
        en = 1'b1;

        // Fill channel 3 with 1..4 while its output is not ready.
        for (int v = 1; v <= 4; v++) begin
            in_valid[3] = 1'b1;
            in_data[3]  = W'(v);
            step();
        end
        in_valid[3] = 1'b0;
        step();

        // Offer one word while full: sets sticky overflow, no push.
        in_valid[3] = 1'b1;
        in_data[3]  = 4'hA;
        step();
        in_valid[3] = 1'b0;
        step();

        // Drain in order; overflow must remain set afterwards.
        out_ready[3] = 1'b1;
        repeat (4) step();
        out_ready[3] = 1'b0;
        repeat (2) step();

        flush = 1'b1;
        step();
        flush = 1'b0;
        step();

        // Occupancy 2 then concurrent push/pop for 20 cycles.
        in_valid[3] = 1'b1;
        in_data[3]  = 4'h5;
        step();
        in_data[3]  = 4'h6;
        step();
        out_ready[3] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data[3] = W'(k + 7);
            step();
        end
        in_valid[3]  = 1'b0;
        out_ready[3] = 1'b0;
        step();

        // Stall: everything offered with en low must be ignored.
        en        = 1'b0;
        in_valid  = '1;
        out_ready = '1;
        for (int i = 0; i < NCH; i++) begin
            in_data[i] = W'(i);
        end
        repeat (3) step();

        // Flush together with pushes: all channels empty next cycle.
        en    = 1'b1;
        flush = 1'b1;
        step();
        clear_inputs();
        repeat (2) step();

        // Randomised traffic with an async reset pulse mid-burst.
        for (int k = 0; k < 400; k++) begin
            en    = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < NCH; i++) begin
                in_valid[i]  = $urandom_range(0, 1) == 1;
                out_ready[i] = $urandom_range(0, 2) != 0;
                in_data[i]   = W'($urandom);
            end
            if (k == 200) begin
                en = 1'b1;
                pulse_reset();
                clear_inputs();
                repeat (4) step();
                // Pushes after reset release must be accepted.
                for (int v = 0; v < 3; v++) begin
                    in_valid[0] = 1'b1;
                    in_data[0]  = W'(v + 9);
                    step();
                end
                in_valid[0]  = 1'b0;
                out_ready[0] = 1'b1;
                repeat (4) step();
            end else begin
                step();
            end
        end

        clear_inputs();
        en = 1'b1;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
